// File: rtl/pi1_rrarb_pkg.sv
// Shared definitions for the pi1 round-robin arbiter: pi1 op encodings,
// arbiter FSM states and the clog2 helper.
package pi1_rrarb_pkg;

    localparam logic [1:0] PINOOP = 2'd0;
    localparam logic [1:0] PIWROP = 2'd1;
    localparam logic [1:0] PIRDOP = 2'd2;
    localparam logic [1:0] PIRWOP = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pi1_rrarb_pick.sv
// Winner selection for pi1_rrarb: maps the pending-request vector and the
// rotation pointer to the index of the master to offer to the slave.
// PI1RRARB_FIXEDPRIO_EN selects fixed priority (lowest index wins, pointer
// ignored); otherwise the search starts at the pointer and wraps.
module pi1_rrarb_pick
    import pi1_rrarb_pkg::*;
#(
    parameter int unsigned MASTERCOUNT = 2
) (
    input  logic [MASTERCOUNT-1:0]               i_req,
    input  logic [clog2(MASTERCOUNT)-1:0]        i_ptr,
    output logic [clog2(MASTERCOUNT)-1:0]        o_winner,
    output logic                                 o_any
);

    localparam int unsigned PTRBITSZ = clog2(MASTERCOUNT);

`ifdef PI1RRARB_FIXEDPRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = |i_ptr;

    // Lowest-index pending request wins; scan downwards so the last hit is the lowest.
    always_comb begin
        o_winner = '0;
        o_any    = |i_req;
        for (int unsigned i = MASTERCOUNT; i > 0; i--) begin
            if (i_req[i-1]) begin
                o_winner = PTRBITSZ'(i - 1);
            end
        end
    end
`else
    // First pending request found scanning ptr, ptr+1, ... with wrap at MASTERCOUNT.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        for (int unsigned k = 0; k < MASTERCOUNT; k++) begin
            int unsigned idx;
            idx = 32'(i_ptr) + k;
            if (idx >= MASTERCOUNT) begin
                idx = idx - MASTERCOUNT;
            end
            if (!o_any && i_req[PTRBITSZ'(idx)]) begin
                o_any    = 1'b1;
                o_winner = PTRBITSZ'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/pi1_rrarb.sv
// pi1_rrarb: shares one pi1 slave port among MASTERCOUNT pi1 masters.
// Each master owns a one-entry request slot; one transaction is in flight at
// the slave at a time and the rotation pointer advances past the master that
// just completed. Define PI1RRARB_FIXEDPRIO_EN for fixed priority (master 0
// highest) instead of round-robin.
module pi1_rrarb
    import pi1_rrarb_pkg::*;
#(
    parameter int unsigned MASTERCOUNT = 2,
    parameter int unsigned ARCHBITSZ   = 32,
    localparam int unsigned ADDRBITSZ  = ARCHBITSZ - clog2(ARCHBITSZ/8),
    localparam int unsigned SELBITSZ   = ARCHBITSZ/8,
    localparam int unsigned OWNBITSZ   = clog2(MASTERCOUNT)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [2*MASTERCOUNT-1:0]          m_pi1_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0]  m_pi1_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0]  m_pi1_data_i,
    input  logic [SELBITSZ*MASTERCOUNT-1:0]   m_pi1_sel_i,
    output logic [ARCHBITSZ*MASTERCOUNT-1:0]  m_pi1_data_o,
    output logic [MASTERCOUNT-1:0]            m_pi1_rdy_o,
    output logic [1:0]                        s_pi1_op_o,
    output logic [ADDRBITSZ-1:0]              s_pi1_addr_o,
    output logic [ARCHBITSZ-1:0]              s_pi1_data_o,
    output logic [SELBITSZ-1:0]               s_pi1_sel_o,
    input  logic [ARCHBITSZ-1:0]              s_pi1_data_i,
    input  logic                              s_pi1_rdy_i,
    output logic [OWNBITSZ-1:0]               owner_o
);

    arb_state_t             r_state;
    logic [OWNBITSZ-1:0]    r_owner;
    logic [OWNBITSZ-1:0]    r_ptr;
    logic [MASTERCOUNT-1:0] r_req_v;
    logic [1:0]             r_op   [MASTERCOUNT];
    logic [ADDRBITSZ-1:0]   r_addr [MASTERCOUNT];
    logic [ARCHBITSZ-1:0]   r_data [MASTERCOUNT];
    logic [SELBITSZ-1:0]    r_sel  [MASTERCOUNT];

    logic [1:0]             w_mop   [MASTERCOUNT];
    logic [ADDRBITSZ-1:0]   w_maddr [MASTERCOUNT];
    logic [ARCHBITSZ-1:0]   w_mdata [MASTERCOUNT];
    logic [SELBITSZ-1:0]    w_msel  [MASTERCOUNT];
    logic [MASTERCOUNT-1:0] w_rdy;
    logic [MASTERCOUNT-1:0] w_load;
    logic [OWNBITSZ-1:0]    w_winner;
    logic                   w_any;
    logic                   w_cmpl;
    logic                   w_issue;

    pi1_rrarb_pick #(
        .MASTERCOUNT (MASTERCOUNT)
    ) u_pick (
        .i_req    (r_req_v),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Unpack the flattened per-master request buses.
    always_comb begin
        for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            w_mop[i]   = m_pi1_op_i[2*i +: 2];
            w_maddr[i] = m_pi1_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
            w_mdata[i] = m_pi1_data_i[ARCHBITSZ*i +: ARCHBITSZ];
            w_msel[i]  = m_pi1_sel_i[SELBITSZ*i +: SELBITSZ];
        end
    end

    assign w_cmpl = (r_state == ST_WAIT) && s_pi1_rdy_i;

    // A slot is ready when empty, or when its own transaction completes this cycle.
    always_comb begin
        w_rdy  = '0;
        w_load = '0;
        for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            w_rdy[i]  = !rst_i && (!r_req_v[i] || (w_cmpl && (r_owner == OWNBITSZ'(i))));
            w_load[i] = w_rdy[i] && (w_mop[i] != PINOOP);
        end
    end

    assign m_pi1_rdy_o  = w_rdy;
    assign m_pi1_data_o = {MASTERCOUNT{s_pi1_data_i}};
    assign owner_o      = r_owner;

    // Offer the winning slot to the slave only while idle; payload follows the winner regardless.
    always_comb begin
        s_pi1_op_o   = PINOOP;
        s_pi1_addr_o = r_addr[w_winner];
        s_pi1_data_o = r_data[w_winner];
        s_pi1_sel_o  = r_sel[w_winner];
        if (!rst_i && (r_state == ST_IDLE) && w_any) begin
            s_pi1_op_o = r_op[w_winner];
        end
    end

    assign w_issue = (s_pi1_op_o != PINOOP) && s_pi1_rdy_i;

    // Slot valid flags: set on accept, cleared on completion without a new op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_v <= '0;
        end else begin
            for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
                if (w_load[i]) begin
                    r_req_v[i] <= 1'b1;
                end else if (w_cmpl && (r_owner == OWNBITSZ'(i))) begin
                    r_req_v[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload capture; contents only matter while the valid flag is set.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            if (w_load[i]) begin
                r_op[i]   <= w_mop[i];
                r_addr[i] <= w_maddr[i];
                r_data[i] <= w_mdata[i];
                r_sel[i]  <= w_msel[i];
            end
        end
    end

    // Arbiter FSM: IDLE offers the winner, WAIT holds until the slave completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_owner <= w_winner;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (s_pi1_rdy_i) begin
                        r_state <= ST_IDLE;
`ifndef PI1RRARB_FIXEDPRIO_EN
                        // Rotate past the completing master so a re-issue ranks last.
                        r_ptr <= (r_owner == OWNBITSZ'(MASTERCOUNT - 1)) ? '0 : r_owner + 1'b1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
